// File: rtl/piso_serializer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out serializer. Takes one word per frame through a
// valid/ready handshake, then shifts its low len bits out one bit per enabled
// clock, MSB-first or LSB-first. A new word can be taken during the last bit
// of a frame, so frames can follow each other with no idle cycle between them.
//
// Parameters
//   DW        maximum frame width in bits (>= 2)
//   IDLE_LVL  level driven on out while no frame is active
//   LW        width of len (derived, do not override)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   enb        clock enable; when low all state holds and no transfer occurs
//   in_valid   producer offers a word on inp
//   in_ready   serializer accepts a word this cycle
//   inp        parallel data, frame occupies inp[len-1:0]
//   len        frame length, 0 or > DW means DW; sampled at accept
//   lsb_first  bit order, sampled at accept (1 = inp[0] first)
//   out        serial data (registered)
//   out_valid  out carries a frame bit (registered)
//   busy       frame in progress (same as out_valid)
//   done       out carries the last bit of the current frame
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int   DW       = 10,
  parameter logic IDLE_LVL = 1'b1,
  parameter int   LW       = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] inp,
  input  logic [LW-1:0] len,
  input  logic          lsb_first,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LW-1:0] DW_LEN = LW'(DW);
  localparam logic [LW-1:0] ONE    = LW'(1);

  state_t        state_reg, state_next;
  logic [LW-1:0] cnt_reg, cnt_next;        // bits remaining, including the one on out
  logic [DW-1:0] shift_reg, shift_next;    // bits still to be sent after out
  logic          lsb_reg, lsb_next;
  logic          out_reg, out_next;
  logic          out_valid_reg, out_valid_next;

  logic [LW-1:0] len_eff;
  logic [DW-1:0] frame_mask;
  logic [DW-1:0] load_word;
  logic [DW-1:0] load_rest;
  logic          load_bit;
  logic          accept;

  // Out-of-range lengths fall back to a full-width frame.
  assign len_eff = ((len == '0) || (len > DW_LEN)) ? DW_LEN : len;

  // Mask off bits above the frame so they can never reach the line.
  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_mask
      assign frame_mask[gi] = (LW'(gi) < len_eff);
    end
  endgenerate

  // MSB-first frames are left-aligned so the first bit is always at DW-1;
  // LSB-first frames stay right-aligned with the first bit at 0.
  always_comb begin
    load_word = inp & frame_mask;
    if (!lsb_first) begin
      load_word = load_word << (DW_LEN - len_eff);
    end
  end

  // The first bit goes straight to the output flop; the remainder is stored
  // already shifted by one position. Vacated positions are filled with ones.
  assign load_bit  = lsb_first ? load_word[0] : load_word[DW-1];
  assign load_rest = lsb_first ? {1'b1, load_word[DW-1:1]}
                               : {load_word[DW-2:0], 1'b1};

  assign done     = (state_reg == SHIFT) && (cnt_reg == ONE);
  assign in_ready = (state_reg == IDLE) || done;
  assign accept   = enb && in_valid && in_ready;

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = out_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '1;
      lsb_reg       <= 1'b0;
      out_reg       <= IDLE_LVL;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      lsb_reg       <= lsb_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    lsb_next       = lsb_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;

    if (enb) begin
      if (accept) begin
        // Covers both a load from IDLE and a back-to-back reload on the last bit.
        state_next     = SHIFT;
        cnt_next       = len_eff;
        shift_next     = load_rest;
        lsb_next       = lsb_first;
        out_next       = load_bit;
        out_valid_next = 1'b1;
      end else begin
        case (state_reg)
          SHIFT: begin
            if (done) begin
              state_next     = IDLE;
              cnt_next       = '0;
              out_next       = IDLE_LVL;
              out_valid_next = 1'b0;
            end else begin
              cnt_next = cnt_reg - ONE;
              if (lsb_reg) begin
                out_next   = shift_reg[0];
                shift_next = {1'b1, shift_reg[DW-1:1]};
              end else begin
                out_next   = shift_reg[DW-1];
                shift_next = {shift_reg[DW-2:0], 1'b1};
              end
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
`timescale 1ns / 1ps
// Directed bench for piso_serializer (DW=10): reset, MSB/LSB frames,
// back-to-back reload, enable gating, length clamping and mid-frame abort.
module tb_piso_serializer;

  localparam int DW = 10;
  localparam int LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enb;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] inp;
  logic [LW-1:0] len;
  logic          lsb_first;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.DW(DW), .IDLE_LVL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .len       (len),
    .lsb_first (lsb_first),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"}, 32'(out), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One frame bit on the line; done and in_ready must be high only on the last.
  task automatic chk_bit(input string tag, input int k, input logic e_out, input logic last);
    string t;
    t = $sformatf("%s[%0d]", tag, k);
    chk({t, ".out"}, 32'(out), 32'(e_out));
    chk({t, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({t, ".busy"}, 32'(busy), 32'd1);
    chk({t, ".done"}, 32'(done), 32'(last));
    chk({t, ".in_ready"}, 32'(in_ready), 32'(last));
  endtask

  // exp holds the frame in transmission order: exp[n-1] is sent first.
  task automatic expect_bits(input string tag, input logic [DW-1:0] exp, input int n,
                             input int from, input int to);
    for (int k = from; k <= to; k++) begin
      chk_bit(tag, k, exp[n-1-k], k == n - 1);
      tick();
    end
    $display("frame %s bits %0d..%0d checked", tag, from, to);
  endtask

  // Present a word for one edge, then scramble the inputs mid-frame.
  task automatic load(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic lsb);
    inp       = d;
    len       = l;
    lsb_first = lsb;
    in_valid  = 1'b1;
    tick();
    $display("accept inp=%h len=%0d lsb_first=%0b", d, l, lsb);
    in_valid  = 1'b0;
    inp       = '1;
    len       = LW'(3);
    lsb_first = ~lsb;
  endtask

  initial begin
    reset     = 1'b0;
    enb       = 1'b1;
    in_valid  = 1'b0;
    inp       = '0;
    len       = '0;
    lsb_first = 1'b0;

    // Reset state and idle after release.
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b1;
    tick();
    tick();
    chk_idle("post_reset");

    // MSB-first full frame: 10'h2C5 -> 1,0,1,1,0,0,0,1,0,1.
    load(10'h2C5, LW'(10), 1'b0);
    expect_bits("msb", 10'h2C5, 10, 0, 9);
    chk_idle("msb_end");

    // LSB-first 4-bit frame of 10'h3F6 -> 0,1,1,0; next word offered on the last bit.
    load(10'h3F6, LW'(4), 1'b1);
    expect_bits("lsb", 10'b0110, 4, 0, 2);
    chk_bit("lsb", 3, 1'b0, 1'b1);
    inp       = 10'h001;
    len       = LW'(2);
    lsb_first = 1'b0;
    in_valid  = 1'b1;
    tick();
    $display("accept inp=001 len=2 lsb_first=0 back-to-back");
    in_valid = 1'b0;
    inp      = '1;
    expect_bits("b2b", 10'b01, 2, 0, 1);
    chk_idle("b2b_end");

    // enb low while idle: in_valid must be ignored.
    enb       = 1'b0;
    in_valid  = 1'b1;
    inp       = 10'h2C5;
    len       = LW'(10);
    lsb_first = 1'b0;
    tick();
    tick();
    chk_idle("enb_idle");
    enb = 1'b1;
    tick();
    $display("accept inp=2c5 len=10 lsb_first=0 after enable");
    in_valid = 1'b0;
    expect_bits("gate", 10'h2C5, 10, 0, 2);
    // Freeze on the 4th bit (value 1) for three cycles.
    enb      = 1'b0;
    in_valid = 1'b1;
    inp      = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("gate_hold", 3, 1'b1, 1'b0);
    end
    enb      = 1'b1;
    in_valid = 1'b0;
    expect_bits("gate", 10'h2C5, 10, 3, 9);
    chk_idle("gate_end");

    // Length clamping: len=0 MSB-first and len=15 LSB-first are full 10-bit frames.
    load(10'h2C5, LW'(0), 1'b0);
    expect_bits("len0", 10'h2C5, 10, 0, 9);
    chk_idle("len0_end");
    load(10'h2C5, LW'(15), 1'b1);
    expect_bits("len15", 10'b1010001101, 10, 0, 9);
    chk_idle("len15_end");

    // Abort at bit 5 with an asynchronous reset, then a fresh frame.
    load(10'h2C5, LW'(10), 1'b0);
    expect_bits("abort", 10'h2C5, 10, 0, 4);
    #1;
    reset = 1'b0;
    #1;
    chk_idle("abort_async");
    tick();
    reset = 1'b1;
    tick();
    chk_idle("abort_release");
    load(10'h3F6, LW'(4), 1'b1);
    expect_bits("fresh", 10'b0110, 4, 0, 3);
    chk_idle("fresh_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
